// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//
// Decodes the registered output of a WIDTH-bit Johnson (twisted-ring) counter
// into a binary phase index and a one-hot phase strobe. It checks each sampled
// code for legality and for step-to-step sequencing, and runs a lock FSM
// (UNLOCKED -> ACQUIRE -> LOCKED). Errors are reported as one-cycle pulses, a
// sticky flag and a saturating counter.
//
// Handshake: in_code is consumed on every cycle with in_valid=1 (there is no
// back-pressure). out_valid is a one-cycle qualifier meaning that phase and
// phase_onehot were refreshed from a legal sample taken on the previous cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      in_code is sampled this cycle
//   in_code       Johnson code from the counter
//   clr_err       clears err_count and err_sticky on the next edge
//   out_valid     phase / phase_onehot updated from a legal sample
//   phase         decoded phase index
//   phase_onehot  bit[phase] set on a legal sample, 0 on an illegal one
//   locked        lock FSM is in LOCKED
//   illegal_err   one-cycle pulse: illegal code sampled
//   skip_err      one-cycle pulse: out-of-sequence legal code while LOCKED
//   err_sticky    set by any error pulse, held until clr_err or rst
//   err_count     saturating count of error pulses
//   state_dbg     current lock FSM state (0 UNLOCKED, 1 ACQUIRE, 2 LOCKED)

module johnson_phase_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2,
  parameter int CNT_W    = 8,
  localparam int PW      = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_code,
  input  logic               clr_err,
  output logic               out_valid,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic               locked,
  output logic               illegal_err,
  output logic               skip_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_count,
  output logic [1:0]         state_dbg
);

  localparam int NPH = 2 * WIDTH;
  localparam int MW  = $clog2(LOCK_CNT + 1);
  localparam int SW  = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    prev_phase;
  logic [MW-1:0]    match_cnt;
  logic [SW-1:0]    miss_cnt;

  logic [WIDTH-1:0] code_inv;
  logic             legal;
  int               ones;
  logic [PW-1:0]    dec_phase;
  logic [PW-1:0]    exp_phase;
  logic             in_seq;
  logic             skip_now;
  logic             err_now;
  logic [NPH-1:0]   onehot_one;

  assign state_dbg  = state;
  assign onehot_one = {{(NPH-1){1'b0}}, 1'b1};

  always_comb begin
    code_inv = ~in_code;
    // x & (x+1) == 0 holds exactly when x is a run of ones at the LSB end
    // (or zero). Applying it to the code and to its inverse covers both
    // legal shapes: 0..01..1 and 1..10..0.
    legal = ((in_code & (in_code + WIDTH'(1))) == '0) ||
            ((code_inv & (code_inv + WIDTH'(1))) == '0);
    ones  = $countones(in_code);
    // Codes that start with ones (or all-zero) count up from phase 0; codes
    // draining ones from the top sit in the second half of the ring.
    if (in_code[WIDTH-1] || (in_code == '0)) begin
      dec_phase = PW'(ones);
    end else begin
      dec_phase = PW'(NPH - ones);
    end
    exp_phase = (prev_phase == PW'(NPH - 1)) ? '0 : prev_phase + PW'(1);
    in_seq    = (dec_phase == exp_phase);
    skip_now  = in_valid && legal && !in_seq && (state == LOCKED);
    err_now   = (in_valid && !legal) || skip_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= UNLOCKED;
      prev_phase   <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      out_valid    <= 1'b0;
      phase        <= '0;
      phase_onehot <= '0;
      locked       <= 1'b0;
      illegal_err  <= 1'b0;
      skip_err     <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
    end else begin
      out_valid   <= in_valid && legal;
      illegal_err <= in_valid && !legal;
      skip_err    <= skip_now;

      if (in_valid) begin
        if (legal) begin
          phase        <= dec_phase;
          phase_onehot <= onehot_one << dec_phase;
          prev_phase   <= dec_phase;
        end else begin
          phase_onehot <= '0;
        end
      end

      // clr_err wins over the old value but not over an error in the same cycle.
      if (clr_err) begin
        err_count  <= err_now ? CNT_W'(1) : '0;
        err_sticky <= err_now;
      end else if (err_now) begin
        err_sticky <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
      end

      case (state)
        UNLOCKED: begin
          if (in_valid && legal) begin
            state     <= ACQUIRE;
            match_cnt <= MW'(1);
          end
        end
        ACQUIRE: begin
          if (in_valid) begin
            if (!legal) begin
              state     <= UNLOCKED;
              match_cnt <= '0;
            end else if (in_seq) begin
              if (int'(match_cnt) + 1 >= LOCK_CNT) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              // A legal jump restarts acquisition from this sample.
              match_cnt <= MW'(1);
            end
          end
        end
        LOCKED: begin
          if (in_valid) begin
            if (legal && in_seq) begin
              miss_cnt <= '0;
            end else if (int'(miss_cnt) + 1 >= MISS_MAX) begin
              state    <= UNLOCKED;
              locked   <= 1'b0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + SW'(1);
            end
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
module tb_johnson_phase_decoder;

  localparam int W = 4;

  // Expected-output bundle layout:
  // {out_valid, phase[2:0], phase_onehot[7:0], locked, illegal_err, skip_err,
  //  err_sticky, err_count[7:0], state_dbg[1:0]}
  localparam int BW = 26;

  localparam logic [1:0] ST_U = 2'd0;
  localparam logic [1:0] ST_A = 2'd1;
  localparam logic [1:0] ST_L = 2'd2;

  typedef struct packed {
    logic          rst;
    logic          v;
    logic          clr;
    logic [W-1:0]  code;
    logic [BW-1:0] e;
    logic [2:0]    se;
  } step_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_code;
  logic          clr_err;

  logic          out_valid;
  logic [2:0]    phase;
  logic [7:0]    phase_onehot;
  logic          locked;
  logic          illegal_err;
  logic          skip_err;
  logic          err_sticky;
  logic [7:0]    err_count;
  logic [1:0]    state_dbg;

  logic          s_out_valid;
  logic [2:0]    s_phase;
  logic [7:0]    s_phase_onehot;
  logic          s_locked;
  logic          s_illegal_err;
  logic          s_skip_err;
  logic          s_err_sticky;
  logic [1:0]    s_err_count;
  logic [1:0]    s_state_dbg;

  logic [BW-1:0] exp_q[$];
  logic [2:0]    sat_q[$];

  int            passed;
  int            total;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  johnson_phase_decoder #(.WIDTH(4), .LOCK_CNT(4), .MISS_MAX(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_err(clr_err),
    .out_valid(out_valid), .phase(phase), .phase_onehot(phase_onehot), .locked(locked),
    .illegal_err(illegal_err), .skip_err(skip_err), .err_sticky(err_sticky),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  // Narrow-counter instance for saturation; shares all inputs with dut.
  johnson_phase_decoder #(.WIDTH(4), .LOCK_CNT(4), .MISS_MAX(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_err(clr_err),
    .out_valid(s_out_valid), .phase(s_phase), .phase_onehot(s_phase_onehot),
    .locked(s_locked), .illegal_err(s_illegal_err), .skip_err(s_skip_err),
    .err_sticky(s_err_sticky), .err_count(s_err_count), .state_dbg(s_state_dbg)
  );

  function automatic logic [BW-1:0] ex(input logic ov, input logic [2:0] ph,
                                       input logic [7:0] oh, input logic [1:0] st,
                                       input logic ill, input logic skp,
                                       input logic sty, input logic [7:0] cnt);
    return {ov, ph, oh, (st == ST_L), ill, skp, sty, cnt, st};
  endfunction

  function automatic step_t mk(input logic r, input logic v, input logic [W-1:0] code,
                               input logic clr, input logic [BW-1:0] e,
                               input logic [2:0] se);
    step_t s;
    s.rst = r; s.v = v; s.code = code; s.clr = clr; s.e = e; s.se = se;
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input step_t s);
    rst      = s.rst;
    in_valid = s.v;
    in_code  = s.code;
    clr_err  = s.clr;
    exp_q.push_back(s.e);
    sat_q.push_back(s.se);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step_t st[$];
    logic [BW-1:0] want;
    logic [2:0] swant;
    st.push_back(mk(1, 0, 4'b0000, 0, ex(0, 0, 8'h00, ST_U, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(1, 0, 4'b0000, 0, ex(0, 0, 8'h00, ST_U, 0, 0, 0, 0), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want  = exp_q.pop_front();
      swant = sat_q.pop_front();
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want || {s_err_sticky, s_err_count} !== swant)
        $display("FAIL reset step %0d got=%h/%h want=%h/%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, {s_err_sticky, s_err_count}, want, swant);
      else passed++;
    end
  endtask

  task automatic test_free_run();
    step_t st[$];
    logic [BW-1:0] want;
    st.push_back(mk(0, 1, 4'b0001, 0, ex(1, 7, 8'h80, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b0000, 0, ex(1, 0, 8'h01, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1000, 0, ex(1, 1, 8'h02, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1100, 0, ex(1, 2, 8'h04, ST_L, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1110, 0, ex(1, 3, 8'h08, ST_L, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1111, 0, ex(1, 4, 8'h10, ST_L, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b0111, 0, ex(1, 5, 8'h20, ST_L, 0, 0, 0, 0), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      void'(sat_q.pop_front());
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want)
        $display("FAIL free_run step %0d got=%h want=%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, want);
      else passed++;
    end
  endtask

  task automatic test_wrap_gaps();
    step_t st[$];
    logic [BW-1:0] want;
    st.push_back(mk(0, 1, 4'b0011, 0, ex(1, 6, 8'h40, ST_L, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b0001, 0, ex(1, 7, 8'h80, ST_L, 0, 0, 0, 0), 3'b000));
    for (int k = 0; k < 3; k++) begin
      // Idle cycles carry a random (ignored) code on the bus.
      st.push_back(mk(0, 0, 4'($urandom_range(0, 15)), 0,
                      ex(0, 7, 8'h80, ST_L, 0, 0, 0, 0), 3'b000));
    end
    st.push_back(mk(0, 1, 4'b0000, 0, ex(1, 0, 8'h01, ST_L, 0, 0, 0, 0), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      void'(sat_q.pop_front());
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want)
        $display("FAIL wrap_gaps step %0d got=%h want=%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, want);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    step_t st[$];
    logic [BW-1:0] want;
    st.push_back(mk(0, 1, 4'b0101, 0, ex(0, 0, 8'h00, ST_L, 1, 0, 1, 1), 3'b000));
    st.push_back(mk(0, 1, 4'b1001, 0, ex(0, 0, 8'h00, ST_U, 1, 0, 1, 2), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      void'(sat_q.pop_front());
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want)
        $display("FAIL illegal step %0d got=%h want=%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, want);
      else passed++;
    end
  endtask

  task automatic test_skip();
    step_t st[$];
    logic [BW-1:0] want;
    // Re-acquire to phase 2.
    st.push_back(mk(0, 1, 4'b0001, 0, ex(1, 7, 8'h80, ST_A, 0, 0, 1, 2), 3'b000));
    st.push_back(mk(0, 1, 4'b0000, 0, ex(1, 0, 8'h01, ST_A, 0, 0, 1, 2), 3'b000));
    st.push_back(mk(0, 1, 4'b1000, 0, ex(1, 1, 8'h02, ST_A, 0, 0, 1, 2), 3'b000));
    st.push_back(mk(0, 1, 4'b1100, 0, ex(1, 2, 8'h04, ST_L, 0, 0, 1, 2), 3'b000));
    // Skip 2 -> 4, then in sequence, then another skip: still locked only if
    // the in-sequence sample cleared the miss count.
    st.push_back(mk(0, 1, 4'b1111, 0, ex(1, 4, 8'h10, ST_L, 0, 1, 1, 3), 3'b000));
    st.push_back(mk(0, 1, 4'b0111, 0, ex(1, 5, 8'h20, ST_L, 0, 0, 1, 3), 3'b000));
    st.push_back(mk(0, 1, 4'b0001, 0, ex(1, 7, 8'h80, ST_L, 0, 1, 1, 4), 3'b000));
    st.push_back(mk(0, 1, 4'b0000, 0, ex(1, 0, 8'h01, ST_L, 0, 0, 1, 4), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      void'(sat_q.pop_front());
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want)
        $display("FAIL skip step %0d got=%h want=%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, want);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    step_t st[$];
    logic [BW-1:0] want;
    logic [2:0] swant;
    logic [W-1:0] bad [5];
    bad = '{4'b0101, 4'b1001, 4'b0110, 4'b1010, 4'b1101};
    st.push_back(mk(1, 0, 4'b0000, 0, ex(0, 0, 8'h00, ST_U, 0, 0, 0, 0), 3'b000));
    for (int k = 0; k < 5; k++) begin
      st.push_back(mk(0, 1, bad[k], 0, ex(0, 0, 8'h00, ST_U, 1, 0, 1, 8'(k + 1)),
                      {1'b1, (k >= 2) ? 2'd3 : 2'(k + 1)}));
    end
    st.push_back(mk(0, 1, 4'b1011, 1, ex(0, 0, 8'h00, ST_U, 1, 0, 1, 1), 3'b101));
    st.push_back(mk(0, 0, 4'b0000, 1, ex(0, 0, 8'h00, ST_U, 0, 0, 0, 0), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want  = exp_q.pop_front();
      swant = sat_q.pop_front();
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want)
        $display("FAIL saturation main step %0d got=%h want=%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, want);
      else passed++;
      total++;
      if ({s_err_sticky, s_err_count} !== swant)
        $display("FAIL saturation narrow step %0d got=%b want=%b", i,
                 {s_err_sticky, s_err_count}, swant);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_acquire();
    step_t st[$];
    logic [BW-1:0] want;
    st.push_back(mk(0, 1, 4'b1000, 0, ex(1, 1, 8'h02, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1100, 0, ex(1, 2, 8'h04, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(1, 1, 4'b1110, 0, ex(0, 0, 8'h00, ST_U, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1110, 0, ex(1, 3, 8'h08, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1111, 0, ex(1, 4, 8'h10, ST_A, 0, 0, 0, 0), 3'b000));
    // Out-of-sequence jump during acquisition: restart count, no skip_err.
    st.push_back(mk(0, 1, 4'b0001, 0, ex(1, 7, 8'h80, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b0000, 0, ex(1, 0, 8'h01, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1000, 0, ex(1, 1, 8'h02, ST_A, 0, 0, 0, 0), 3'b000));
    st.push_back(mk(0, 1, 4'b1100, 0, ex(1, 2, 8'h04, ST_L, 0, 0, 0, 0), 3'b000));
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      void'(sat_q.pop_front());
      total++;
      if ({out_valid, phase, phase_onehot, locked, illegal_err, skip_err, err_sticky,
           err_count, state_dbg} !== want)
        $display("FAIL reset_mid_acquire step %0d got=%h want=%h", i,
                 {out_valid, phase, phase_onehot, locked, illegal_err, skip_err,
                  err_sticky, err_count, state_dbg}, want);
      else passed++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    clr_err  = 1'b0;
    test_reset();
    test_free_run();
    test_wrap_gaps();
    test_illegal();
    test_skip();
    test_saturation();
    test_reset_mid_acquire();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
